// File: rtl/mandel_frame_scheduler.sv
// Mandelbrot frame scheduler: raster-order job issue to NUM_ENGINES engines in strict
// round-robin, in-order retirement into a flagged pixel stream, per-frame config latch.
module mandel_frame_scheduler #(
    parameter int X_SIZE      = 320,
    parameter int Y_SIZE      = 240,
    parameter int NUM_ENGINES = 4,
    parameter int ITER_W      = 8,
    parameter int OFS_W       = 25,
    localparam int XW = $clog2(X_SIZE),
    localparam int YW = $clog2(Y_SIZE),
    localparam int PW = $clog2(NUM_ENGINES),
    localparam int CW = $clog2(NUM_ENGINES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          cfg_continuous,
    input  logic [ITER_W-1:0]             cfg_iter_max,
    input  logic [2:0]                    cfg_zoom,
    input  logic [OFS_W-1:0]              cfg_x_offset,
    input  logic [OFS_W-1:0]              cfg_y_offset,
    output logic [ITER_W-1:0]             frame_iter_max,
    output logic [2:0]                    frame_zoom,
    output logic [OFS_W-1:0]              frame_x_offset,
    output logic [OFS_W-1:0]              frame_y_offset,
    output logic                          busy,
    output logic [NUM_ENGINES-1:0]        eng_req_valid,
    input  logic [NUM_ENGINES-1:0]        eng_req_ready,
    output logic [XW-1:0]                 eng_x,
    output logic [YW-1:0]                 eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic [NUM_ENGINES-1:0]        eng_ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_iter,
    output logic                          out_first,
    output logic                          out_last_x,
    output logic                          out_last_y
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPATCH = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    logic [1:0]        state_reg;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [PW-1:0]     d_ptr_reg;
    logic [PW-1:0]     r_ptr_reg;
    logic [CW-1:0]     inflight_reg;
    logic [XW-1:0]     tag_x_reg [NUM_ENGINES];
    logic [YW-1:0]     tag_y_reg [NUM_ENGINES];
    logic [ITER_W-1:0] iter_slice [NUM_ENGINES];

    logic              out_valid_reg;
    logic [ITER_W-1:0] out_iter_reg;
    logic              out_first_reg;
    logic              out_last_x_reg;
    logic              out_last_y_reg;
    logic [ITER_W-1:0] frame_iter_max_reg;
    logic [2:0]        frame_zoom_reg;
    logic [OFS_W-1:0]  frame_x_offset_reg;
    logic [OFS_W-1:0]  frame_y_offset_reg;

    logic can_issue, dispatch_fire, out_free, retire_fire;
    logic last_pixel, drain_done, frame_load;

    assign can_issue     = (state_reg == ST_DISPATCH) && (inflight_reg < CW'(NUM_ENGINES));
    assign dispatch_fire = can_issue && eng_req_ready[d_ptr_reg];
    assign out_free      = !out_valid_reg || out_ready;
    assign retire_fire   = eng_done[r_ptr_reg] && (inflight_reg != '0) && out_free;
    assign last_pixel    = (x_reg == XW'(X_SIZE - 1)) && (y_reg == YW'(Y_SIZE - 1));
    assign drain_done    = (state_reg == ST_DRAIN) && (inflight_reg == '0) && out_free;
    // Both frame entry points (idle start and continuous restart) latch config the same way.
    assign frame_load    = ((state_reg == ST_IDLE) && frame_start) || (drain_done && cfg_continuous);

    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
        assign eng_req_valid[gi] = can_issue && (d_ptr_reg == PW'(gi));
        assign eng_ack[gi]       = retire_fire && (r_ptr_reg == PW'(gi));
        assign iter_slice[gi]    = eng_iter[gi*ITER_W +: ITER_W];
    end

    always_ff @(posedge clk) begin
        if (dispatch_fire) begin
            tag_x_reg[d_ptr_reg] <= x_reg;
            tag_y_reg[d_ptr_reg] <= y_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            x_reg              <= '0;
            y_reg              <= '0;
            d_ptr_reg          <= '0;
            r_ptr_reg          <= '0;
            inflight_reg       <= '0;
            out_valid_reg      <= 1'b0;
            out_iter_reg       <= '0;
            out_first_reg      <= 1'b0;
            out_last_x_reg     <= 1'b0;
            out_last_y_reg     <= 1'b0;
            frame_iter_max_reg <= '0;
            frame_zoom_reg     <= '0;
            frame_x_offset_reg <= '0;
            frame_y_offset_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE:     if (frame_start) state_reg <= ST_DISPATCH;
                ST_DISPATCH: if (dispatch_fire && last_pixel) state_reg <= ST_DRAIN;
                ST_DRAIN:    if (drain_done) state_reg <= cfg_continuous ? ST_DISPATCH : ST_IDLE;
                default:     state_reg <= ST_IDLE;
            endcase

            // frame_load only happens with nothing in flight, so it never races a dispatch or retire.
            if (frame_load) begin
                frame_iter_max_reg <= cfg_iter_max;
                frame_zoom_reg     <= cfg_zoom;
                frame_x_offset_reg <= cfg_x_offset;
                frame_y_offset_reg <= cfg_y_offset;
                x_reg              <= '0;
                y_reg              <= '0;
                d_ptr_reg          <= '0;
                r_ptr_reg          <= '0;
            end else begin
                if (dispatch_fire) begin
                    d_ptr_reg <= d_ptr_reg + PW'(1);
                    if (x_reg == XW'(X_SIZE - 1)) begin
                        x_reg <= '0;
                        y_reg <= last_pixel ? '0 : y_reg + YW'(1);
                    end else begin
                        x_reg <= x_reg + XW'(1);
                    end
                end
                if (retire_fire) r_ptr_reg <= r_ptr_reg + PW'(1);
            end

            case ({dispatch_fire, retire_fire})
                2'b10:   inflight_reg <= inflight_reg + CW'(1);
                2'b01:   inflight_reg <= inflight_reg - CW'(1);
                default: inflight_reg <= inflight_reg;
            endcase

            if (retire_fire) begin
                out_valid_reg  <= 1'b1;
                out_iter_reg   <= iter_slice[r_ptr_reg];
                out_first_reg  <= (tag_x_reg[r_ptr_reg] == '0) && (tag_y_reg[r_ptr_reg] == '0);
                out_last_x_reg <= tag_x_reg[r_ptr_reg] == XW'(X_SIZE - 1);
                out_last_y_reg <= tag_y_reg[r_ptr_reg] == YW'(Y_SIZE - 1);
            end else if (out_ready) begin
                out_valid_reg  <= 1'b0;
            end
        end
    end

    assign busy           = state_reg != ST_IDLE;
    assign eng_x          = x_reg;
    assign eng_y          = y_reg;
    assign out_valid      = out_valid_reg;
    assign out_iter       = out_iter_reg;
    assign out_first      = out_first_reg;
    assign out_last_x     = out_last_x_reg;
    assign out_last_y     = out_last_y_reg;
    assign frame_iter_max = frame_iter_max_reg;
    assign frame_zoom     = frame_zoom_reg;
    assign frame_x_offset = frame_x_offset_reg;
    assign frame_y_offset = frame_y_offset_reg;

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Bench for mandel_frame_scheduler: latency-programmable engine models plus a raster-order
// pixel scoreboard; reduced frame size keeps every scenario short.
`timescale 1ns/1ps
module tb_mandel_frame_scheduler;

    localparam int X_SIZE = 12;
    localparam int Y_SIZE = 5;
    localparam int NE     = 4;
    localparam int ITER_W = 8;
    localparam int OFS_W  = 25;
    localparam int XW     = $clog2(X_SIZE);
    localparam int YW     = $clog2(Y_SIZE);
    localparam int PIX    = X_SIZE * Y_SIZE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic cfg_continuous = 1'b0;
    logic [ITER_W-1:0] cfg_iter_max = '0;
    logic [2:0] cfg_zoom = '0;
    logic [OFS_W-1:0] cfg_x_offset = '0;
    logic [OFS_W-1:0] cfg_y_offset = '0;
    logic out_ready = 1'b1;

    logic [ITER_W-1:0] frame_iter_max;
    logic [2:0] frame_zoom;
    logic [OFS_W-1:0] frame_x_offset, frame_y_offset;
    logic busy, out_valid, out_first, out_last_x, out_last_y;
    logic [NE-1:0] eng_req_valid, eng_req_ready, eng_done, eng_ack;
    logic [XW-1:0] eng_x;
    logic [YW-1:0] eng_y;
    logic [NE*ITER_W-1:0] eng_iter;
    logic [ITER_W-1:0] out_iter;

    int lat_mode = 0;

    mandel_frame_scheduler #(
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .NUM_ENGINES(NE), .ITER_W(ITER_W), .OFS_W(OFS_W)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .cfg_continuous(cfg_continuous),
        .cfg_iter_max(cfg_iter_max), .cfg_zoom(cfg_zoom),
        .cfg_x_offset(cfg_x_offset), .cfg_y_offset(cfg_y_offset),
        .frame_iter_max(frame_iter_max), .frame_zoom(frame_zoom),
        .frame_x_offset(frame_x_offset), .frame_y_offset(frame_y_offset),
        .busy(busy), .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
        .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done), .eng_iter(eng_iter),
        .eng_ack(eng_ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .out_first(out_first), .out_last_x(out_last_x),
        .out_last_y(out_last_y)
    );

    always #5 clk = ~clk;

    function automatic int pick_lat(input int e);
        if (lat_mode == 0) return 3;
        if (lat_mode == 1) return (e == 0) ? 40 : (e == 1) ? 5 : (e == 2) ? 20 : 1;
        return int'($urandom_range(12, 1));
    endfunction

    // Engine model: accepts a job when idle, answers after its latency, holds done until acked.
    for (genvar gi = 0; gi < NE; gi++) begin : g_eng
        logic busy_m, done_m;
        int cnt_m;
        logic [ITER_W-1:0] res_m;
        assign eng_req_ready[gi] = !busy_m && !done_m;
        assign eng_done[gi] = done_m;
        assign eng_iter[gi*ITER_W +: ITER_W] = res_m;
        always @(posedge clk) begin
            if (reset) begin
                busy_m <= 1'b0; done_m <= 1'b0; cnt_m <= 0; res_m <= '0;
            end else begin
                if (eng_req_valid[gi] && eng_req_ready[gi]) begin
                    busy_m <= 1'b1;
                    cnt_m  <= pick_lat(gi) - 1;
                    res_m  <= ITER_W'(int'(eng_x) * 3 + int'(eng_y) * 5 + int'(frame_iter_max));
                end else if (busy_m) begin
                    if (cnt_m == 0) begin busy_m <= 1'b0; done_m <= 1'b1; end
                    else cnt_m <= cnt_m - 1;
                end
                if (eng_ack[gi]) done_m <= 1'b0;
            end
        end
    end

    int n_vec = 0, n_err = 0;
    int exp_idx = 0, exp_r = 0, frames_done = 0;
    int pix_cnt = 0, first_cnt = 0, lastx_cnt = 0;
    logic [ITER_W-1:0] cur_iter_max = '0, next_iter_max = '0;
    logic hold_pending = 1'b0;
    logic [ITER_W-1:0] held_iter = '0;
    logic [2:0] held_flags = '0;

    // One cycle: scoreboard checks at the negedge, then return just after the next posedge.
    task automatic tick();
        int ex, ey;
        logic [ITER_W-1:0] ei;
        logic [2:0] ef, af;
        logic [NE-1:0] ack_exp;
        @(negedge clk);
        if (reset) begin
            exp_idx = 0; exp_r = 0; hold_pending = 1'b0;
        end else begin
            af = {out_first, out_last_x, out_last_y};
            if (hold_pending) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_iter !== held_iter || af !== held_flags) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b iter=%0d flags=%b, required v=1 iter=%0d flags=%b",
                             out_valid, out_iter, af, held_iter, held_flags);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                n_vec++;
                if (eng_ack !== '0) begin
                    n_err++;
                    $display("FAIL ack_during_stall: got eng_ack=%b, required 0", eng_ack);
                end
            end else if (eng_ack !== '0) begin
                ack_exp = '0;
                ack_exp[exp_r] = 1'b1;
                n_vec++;
                if (eng_ack !== ack_exp) begin
                    n_err++;
                    $display("FAIL ack_order: got eng_ack=%b, required %b", eng_ack, ack_exp);
                end
                exp_r = (exp_r + 1) % NE;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                ex = exp_idx % X_SIZE;
                ey = exp_idx / X_SIZE;
                ei = ITER_W'(ex * 3 + ey * 5 + int'(cur_iter_max));
                ef = {(ex == 0) && (ey == 0), ex == X_SIZE - 1, ey == Y_SIZE - 1};
                n_vec++;
                if (out_iter !== ei || af !== ef) begin
                    n_err++;
                    $display("FAIL pixel(%0d,%0d): got iter=%0d flags=%b, required iter=%0d flags=%b",
                             ex, ey, out_iter, af, ei, ef);
                end
                pix_cnt++;
                if (out_first === 1'b1) first_cnt++;
                if (out_last_x === 1'b1) lastx_cnt++;
                exp_idx++;
                if (exp_idx == PIX) begin
                    exp_idx = 0;
                    frames_done++;
                    $display("frame %0d complete: %0d pixels, iter_max %0d", frames_done, PIX, cur_iter_max);
                    cur_iter_max = next_iter_max;
                end
            end
            hold_pending = out_valid && !out_ready;
            held_iter = out_iter;
            held_flags = af;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [ITER_W-1:0] iter, input logic cont);
        cfg_iter_max = iter;
        cfg_zoom = 3'($urandom);
        cfg_x_offset = OFS_W'($urandom);
        cfg_y_offset = OFS_W'($urandom);
        cfg_continuous = cont;
        cur_iter_max = iter;
        next_iter_max = iter;
        exp_r = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            out_ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic run_until_pixels(input int target, input bit rnd);
        int n = 0;
        while (pix_cnt < target && n < 3000) begin
            out_ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b1;
        n_vec++;
        if (pix_cnt < target) begin
            n_err++;
            $display("FAIL pixel_timeout: got %0d pixels, required %0d", pix_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_vec++;
        if ({busy, eng_req_valid, eng_ack, out_valid, out_first, out_last_x, out_last_y} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy=%b req=%b ack=%b v=%b flags=%b%b%b, required all 0",
                     busy, eng_req_valid, eng_ack, out_valid, out_first, out_last_x, out_last_y);
        end
        n_vec++;
        if (out_iter !== '0 || eng_x !== '0 || eng_y !== '0 || frame_iter_max !== '0 ||
            frame_zoom !== '0 || frame_x_offset !== '0 || frame_y_offset !== '0) begin
            n_err++;
            $display("FAIL reset_data: got iter=%0d x=%0d y=%0d fim=%0d zoom=%0d, required all 0",
                     out_iter, eng_x, eng_y, frame_iter_max, frame_zoom);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || eng_req_valid !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b req=%b, required 0/0", busy, eng_req_valid);
        end
    endtask

    task automatic test_full_frame();
        int p0 = pix_cnt, f0 = first_cnt, l0 = lastx_cnt;
        lat_mode = 0;
        start_frame(8'd50, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || eng_req_valid !== NE'(1)) begin
            n_err++;
            $display("FAIL first_dispatch: got busy=%b req=%b, required 1/%b", busy, eng_req_valid, NE'(1));
        end
        n_vec++;
        if (frame_iter_max !== 8'd50 || frame_zoom !== cfg_zoom ||
            frame_x_offset !== cfg_x_offset || frame_y_offset !== cfg_y_offset) begin
            n_err++;
            $display("FAIL cfg_latch: got fim=%0d zoom=%0d xo=%h yo=%h, required 50 %0d %h %h",
                     frame_iter_max, frame_zoom, frame_x_offset, frame_y_offset,
                     cfg_zoom, cfg_x_offset, cfg_y_offset);
        end
        wait_idle(4000, 1'b0);
        n_vec++;
        if (pix_cnt - p0 != PIX || first_cnt - f0 != 1 || lastx_cnt - l0 != Y_SIZE) begin
            n_err++;
            $display("FAIL frame_counts: got pix=%0d first=%0d lastx=%0d, required %0d 1 %0d",
                     pix_cnt - p0, first_cnt - f0, lastx_cnt - l0, PIX, Y_SIZE);
        end
    endtask

    task automatic test_mixed_latency();
        int p0 = pix_cnt;
        lat_mode = 1;
        start_frame(ITER_W'($urandom), 1'b0);
        wait_idle(8000, 1'b0);
        n_vec++;
        if (pix_cnt - p0 != PIX || exp_idx != 0) begin
            n_err++;
            $display("FAIL mixed_latency_count: got pix=%0d idx=%0d, required %0d 0", pix_cnt - p0, exp_idx, PIX);
        end
    endtask

    task automatic test_backpressure();
        int p0 = pix_cnt, p1;
        lat_mode = 2;
        start_frame(ITER_W'($urandom), 1'b0);
        run_until_pixels(p0 + 20, 1'b1);
        p1 = pix_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        n_vec++;
        if (eng_req_valid !== '0 || out_valid !== 1'b1 || pix_cnt != p1) begin
            n_err++;
            $display("FAIL stall_state: got req=%b v=%b pix=%0d, required 0 1 %0d", eng_req_valid, out_valid, pix_cnt, p1);
        end
        wait_idle(4000, 1'b1);
        n_vec++;
        if (pix_cnt - p0 != PIX) begin
            n_err++;
            $display("FAIL backpressure_count: got %0d pixels, required %0d", pix_cnt - p0, PIX);
        end
    endtask

    task automatic test_cfg_latch_continuous();
        int p0 = pix_cnt, fd = frames_done, n = 0;
        lat_mode = 2;
        start_frame(8'd50, 1'b0);
        run_until_pixels(p0 + 10, 1'b1);
        cfg_iter_max = 8'd100;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_vec++;
        if (frame_iter_max !== 8'd50 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_cfg: got fim=%0d busy=%b, required 50 1", frame_iter_max, busy);
        end
        cfg_continuous = 1'b1;
        next_iter_max = 8'd100;
        while (frames_done == fd && n < 4000) begin
            out_ready = ($urandom_range(3, 0) != 0);
            tick();
            n++;
        end
        cfg_continuous = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (busy !== 1'b1 || eng_req_valid !== NE'(1) || frame_iter_max !== 8'd100) begin
            n_err++;
            $display("FAIL continuous_restart: got busy=%b req=%b fim=%0d, required 1 %b 100",
                     busy, eng_req_valid, frame_iter_max, NE'(1));
        end
        wait_idle(4000, 1'b1);
        n_vec++;
        if (pix_cnt - p0 != 2 * PIX || frames_done - fd != 2) begin
            n_err++;
            $display("FAIL continuous_count: got pix=%0d frames=%0d, required %0d 2", pix_cnt - p0, frames_done - fd, 2 * PIX);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0 = pix_cnt, f0;
        lat_mode = 2;
        start_frame(8'd77, 1'b0);
        run_until_pixels(p0 + 25, 1'b1);
        reset = 1'b1;
        tick();
        n_vec++;
        if ({busy, eng_req_valid, eng_ack, out_valid, out_first, out_last_x, out_last_y} !== '0 ||
            out_iter !== '0 || frame_iter_max !== '0 || eng_x !== '0 || eng_y !== '0) begin
            n_err++;
            $display("FAIL midframe_reset: got busy=%b req=%b v=%b iter=%0d fim=%0d x=%0d, required all 0",
                     busy, eng_req_valid, out_valid, out_iter, frame_iter_max, eng_x);
        end
        reset = 1'b0;
        tick();
        p0 = pix_cnt;
        f0 = first_cnt;
        start_frame(8'd33, 1'b0);
        wait_idle(4000, 1'b1);
        n_vec++;
        if (pix_cnt - p0 != PIX || first_cnt - f0 != 1) begin
            n_err++;
            $display("FAIL restart_frame: got pix=%0d first=%0d, required %0d 1", pix_cnt - p0, first_cnt - f0, PIX);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mixed_latency();
        test_backpressure();
        test_cfg_latch_continuous();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
